// File: rtl/sum_block_accumulator.sv
// Accumulates BLOCK_LEN unsigned adder sums per block and holds the total for a valid/ready handshake.
// Optional ACC_SATURATE_EN: clamp the total to all-ones on carry instead of wrapping.
module sum_block_accumulator #(
  parameter int unsigned N         = 8,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned BLOCK_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     in_sum_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_acc_o,
  output logic             out_ovf_o
);

  localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [SUM_W-1:0]   sum_ext;

  // One extra bit captures the carry out of the accumulator.
  assign sum_ext = SUM_W'(acc_q) + SUM_W'(in_sum_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: clear beats both the input accept and the output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = sum_ext[ACC_W-1:0];
            if (sum_ext[ACC_W]) begin
              ovf_d = 1'b1;
`ifdef ACC_SATURATE_EN
              acc_d = {ACC_W{1'b1}};
`endif
            end
            if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_HOLD);
  assign out_acc_o   = acc_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Directed bench for sum_block_accumulator: default instance plus an ACC_W=10 instance for overflow.
module tb_sum_block_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_acc;
  logic        out_ovf;

  logic        clear2;
  logic        in_valid2;
  logic        in_ready2;
  logic [7:0]  in_sum2;
  logic        out_valid2;
  logic        out_ready2;
  logic [9:0]  out_acc2;
  logic        out_ovf2;

  logic [7:0]  vec [8];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sum_block_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sum_i(in_sum),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_acc_o(out_acc), .out_ovf_o(out_ovf)
  );

  sum_block_accumulator #(.N(8), .ACC_W(10), .BLOCK_LEN(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_sum_i(in_sum2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .out_acc_o(out_acc2), .out_ovf_o(out_ovf2)
  );

  // Drives the 8 reference sums; returns at the negedge after the last valid cycle.
  task automatic drive_sums(input bit gapped);
    for (int i = 0; i < 8; i++) begin
      if (gapped) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_sum   = 8'hFF;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = vec[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = 8'h00;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_acc !== 16'd0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%0b acc=%0d ovf=%0b, required 0/0/0", out_valid, out_acc, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%0b/%0b, required 1/1", in_ready, in_ready2);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    drive_sums(1'b0);
    total++;
    if (out_valid !== 1'b1 || out_acc !== 16'd975 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: valid=%0b acc=%0d ovf=%0b, required 1/975/0", out_valid, out_acc, out_ovf);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 16'd0) begin
      bad++;
      $display("FAIL basic_release: valid=%0b ready=%0b acc=%0d, required 0/1/0", out_valid, in_ready, out_acc);
    end
  endtask

  task automatic test_overflow;
    logic [9:0] exp_mid;
    logic [9:0] exp_fin;
`ifdef ACC_SATURATE_EN
    exp_mid = 10'd1023;
    exp_fin = 10'd1023;
`else
    exp_mid = 10'd251;
    exp_fin = 10'd1016;
`endif
    out_ready2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 5) begin
        total++;
        if (out_acc2 !== exp_mid || out_ovf2 !== 1'b1) begin
          bad++;
          $display("FAIL ovf_running: acc=%0d ovf=%0b, required %0d/1", out_acc2, out_ovf2, exp_mid);
        end
      end
      in_valid2 = 1'b1;
      in_sum2   = 8'd255;
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    total++;
    if (out_valid2 !== 1'b1 || out_acc2 !== exp_fin || out_ovf2 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_result: valid=%0b acc=%0d ovf=%0b, required 1/%0d/1", out_valid2, out_acc2, out_ovf2, exp_fin);
    end
    @(negedge clk);
    total++;
    if (out_ovf2 !== 1'b0 || out_acc2 !== 10'd0) begin
      bad++;
      $display("FAIL ovf_cleared: acc=%0d ovf=%0b, required 0/0", out_acc2, out_ovf2);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive_sums(1'b0);
    in_valid = 1'b1;
    in_sum   = 8'd50;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 16'd975) begin
        bad++;
        $display("FAIL bp_hold[%0d]: ready=%0b valid=%0b acc=%0d, required 0/1/975", i, in_ready, out_valid, out_acc);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 16'd0) begin
      bad++;
      $display("FAIL bp_handshake: valid=%0b ready=%0b acc=%0d, required 0/1/0", out_valid, in_ready, out_acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_acc !== 16'd50) begin
      bad++;
      $display("FAIL bp_next_block: acc=%0d, required 50", out_acc);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_gapped;
    out_ready = 1'b1;
    drive_sums(1'b1);
    total++;
    if (out_valid !== 1'b1 || out_acc !== 16'd975 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL gapped_result: valid=%0b acc=%0d ovf=%0b, required 1/975/0", out_valid, out_acc, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = vec[i];
    end
    @(negedge clk);
    total++;
    if (out_acc !== 16'd340) begin
      bad++;
      $display("FAIL clear_partial: acc=%0d, required 340", out_acc);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 8'd200;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_acc !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_effect: acc=%0d valid=%0b ready=%0b, required 0/0/1", out_acc, out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL clear_no_early_valid[%0d]: valid=%0b, required 0", i, out_valid);
      end
      in_valid = 1'b1;
      in_sum   = vec[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_acc !== 16'd975) begin
      bad++;
      $display("FAIL clear_result: valid=%0b acc=%0d, required 1/975", out_valid, out_acc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_hold;
    out_ready = 1'b0;
    drive_sums(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_acc !== 16'd0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL rst_hold: valid=%0b acc=%0d ovf=%0b, required 0/0/0", out_valid, out_acc, out_ovf);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive_sums(1'b0);
    total++;
    if (out_valid !== 1'b1 || out_acc !== 16'd975) begin
      bad++;
      $display("FAIL rst_fresh_block: valid=%0b acc=%0d, required 1/975", out_valid, out_acc);
    end
    @(negedge clk);
  endtask

  initial begin
    vec[0] = 8'd108; vec[1] = 8'd73;  vec[2] = 8'd159; vec[3] = 8'd149;
    vec[4] = 8'd108; vec[5] = 8'd140; vec[6] = 8'd142; vec[7] = 8'd96;
    rst_n = 1'b0;
    clear = 1'b0; in_valid = 1'b0; in_sum = 8'd0; out_ready = 1'b0;
    clear2 = 1'b0; in_valid2 = 1'b0; in_sum2 = 8'd0; out_ready2 = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gapped();
    test_clear();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
